// File: rtl/regfile_pkg.sv
// Shared defaults for the 8x16 register bank: geometry and the value loaded on reset.
`timescale 1ns/1ps
package regfile_pkg;
  localparam int WIDTH_DEF      = 16;
  localparam int DEPTH_DEF      = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam logic RESET_BIT    = 1'b0;
endpackage

// File: rtl/register_file_8x16.sv
// General-purpose register bank: single shared address, synchronous write with priority,
// registered read, asynchronous active-low clear of all entries and the read output.
`timescale 1ns/1ps
module register_file_8x16
  import regfile_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  WrEn,
  input  logic [WIDTH-1:0]      WrData,
  input  logic                  RdEn,
  output logic [WIDTH-1:0]      RdData
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_BIT}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;
  logic             addr_ok;
  logic [IDX_W-1:0] idx;

  assign addr_ok = ({1'b0, Address} < DEPTH_L);
  assign idx     = Address[IDX_W-1:0];

  // Write wins over read; an out-of-range read returns zero, an out-of-range write is dropped.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (WrEn) begin
      if (addr_ok) mem_d[idx] = WrData;
    end else if (RdEn) begin
      rd_data_d = addr_ok ? mem_q[idx] : RESET_VAL;
    end
  end

  // Array kept in flops so the reset loop can clear every entry at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      rd_data_q <= RESET_VAL;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign RdData = rd_data_q;

endmodule

// File: tb/tb_register_file_8x16.sv
// Directed bench for register_file_8x16: reset hold, write priority, readback,
// out-of-range access, idle hold, back-to-back write/read and a sub-cycle reset pulse.
`timescale 1ns/1ps
module tb_register_file_8x16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  Address;
  logic        WrEn;
  logic [15:0] WrData;
  logic        RdEn;
  logic [15:0] RdData;

  int checks   = 0;
  int failures = 0;

  register_file_8x16 dut (
    .CLK     (CLK),
    .RST     (RST),
    .Address (Address),
    .WrEn    (WrEn),
    .WrData  (WrData),
    .RdEn    (RdEn),
    .RdData  (RdData)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [3:0] a, input logic [15:0] d);
    WrEn = we; RdEn = re; Address = a; WrData = d;
  endtask

  initial begin
    RST = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    #1;
    check("reset_initial", RdData, 16'h0000);

    // Reset held: write+read requests must have no effect
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 4'(i), 16'hA5A5);
      step();
      check($sformatf("reset_hold_%0d", i), RdData, 16'h0000);
    end
    RST = 1'b1;

    // Write priority: reads requested together with writes never happen
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 4'(i), 16'(i + 1));
      step();
      check($sformatf("wr_prio_%0d", i), RdData, 16'h0000);
    end

    // Readback
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 4'(i), 16'h0000);
      step();
      check($sformatf("readback_%0d", i), RdData, 16'(i + 1));
    end

    // Idle: RdData holds its last value (8)
    drive(1'b0, 1'b0, 4'd2, 16'h1234);
    step();
    step();
    check("idle_hold", RdData, 16'h0008);

    // Out-of-range write ignored, RdData holds during the write
    drive(1'b1, 1'b0, 4'd9, 16'hBEEF);
    step();
    check("oor_write_hold", RdData, 16'h0008);
    drive(1'b0, 1'b1, 4'd9, 16'h0000);
    step();
    check("oor_read", RdData, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 4'(i), 16'h0000);
      step();
      check($sformatf("oor_unchanged_%0d", i), RdData, 16'(i + 1));
    end

    // Back-to-back write then read of entry 7
    drive(1'b1, 1'b0, 4'd7, 16'hFFFF);
    step();
    check("b2b_write_hold", RdData, 16'h0008);
    drive(1'b0, 1'b1, 4'd7, 16'h0000);
    step();
    check("b2b_read", RdData, 16'hFFFF);

    // Sub-cycle asynchronous reset pulse between edges
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    #2;
    RST = 1'b0;
    #0.5;
    RST = 1'b1;
    #0.1;
    check("async_pulse_rddata", RdData, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 4'(i), 16'h0000);
      step();
      check($sformatf("post_reset_%0d", i), RdData, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file_8x16.md
Name: register_file_8x16

Overview:
- Synchronous-write, registered-read storage array: 8 entries x 16 bits, single shared address port.
- Used as the general-purpose configuration/data register bank of the digital system.
- One access per cycle, either a write or a read; write has priority.
- Asynchronous active-low reset clears every entry and the read output.

Parameters:
- WIDTH, 16, data width of each entry and of WrData/RdData.
- DEPTH, 8, number of entries.
- ADDR_WIDTH, 4, width of Address; only indices 0..DEPTH-1 are valid.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset; clears all entries and RdData.
- Address  input  ADDR_WIDTH  entry index for the current write or read.
- WrEn  input  1  write enable.
- WrData  input  WIDTH  data written when WrEn=1.
- RdEn  input  1  read enable.
- RdData  output  WIDTH  registered read data.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-low, RST.
- Reset (RST=0, asynchronous, no clock needed):
  - All DEPTH entries go to 0 and RdData goes to 0 immediately.
  - A sub-cycle low pulse (e.g. 0.5 ns) must fully clear the array.
  - While RST=0, writes and reads are blocked.
- Write: on the rising CLK edge with RST=1, WrEn=1 and Address<DEPTH, mem[Address] <= WrData.
  - RdData holds its previous value during a write cycle.
- Read: on the rising CLK edge with RST=1, WrEn=0, RdEn=1 and Address<DEPTH, RdData <= mem[Address].
  - Latency: 1 cycle, with data valid after the edge that samples the request.
- Simultaneous WrEn=1 and RdEn=1: write only. No read is performed and RdData holds. There is no write-through.
- WrEn=0, RdEn=0: no state change; RdData holds.
- Out-of-range address (Address>=DEPTH, i.e. Address[3]=1):
  - A write is ignored; no entry is modified.
  - A read loads RdData with 0.
- Read after write to the same address in the next cycle returns the new data.
- Entries retain their value indefinitely until written or reset.
- No combinational path from any input to RdData.

Decomposition:
- Shared package regfile_pkg: WIDTH/DEPTH/ADDR_WIDTH defaults and the reset value constant (all zeros).
- No sub-module. The array and output register are a single always block with an asynchronous reset branch.
- The reset branch uses a for-loop clear, so the array must be flops, not inferred RAM.

Test Plan:
- Reset hold:
  - Stimulus: RST=0, WrEn=1, RdEn=1, sweep Address 0..7 with one cycle each.
  - Response: RdData==0 every cycle and nothing is written.
- Write priority:
  - Stimulus: RST=1, WrEn=1, RdEn=1, Address=i, WrData=i+1 for i=0..7.
  - Response: RdData stays 0 throughout, i.e. no read occurs during writes.
- Readback:
  - Stimulus: WrEn=0, RdEn=1, Address=i for i=0..7.
  - Response: one cycle later RdData==i+1 for each i (1..8).
- Asynchronous reset:
  - Stimulus: after the readback, a 0.5 ns RST low pulse between clock edges, then read Address 0..7.
  - Response: RdData==0 immediately after the pulse and 0 for every address.
- Out of range and idle:
  - Stimulus: write 16'hBEEF to Address 9.
  - Response: entries 0..7 are unchanged. Reading Address 9 gives RdData=0. With RdEn=0 and WrEn=0, RdData holds its last value.
- Back-to-back:
  - Stimulus: write 16'hFFFF to entry 7, then read entry 7 on the next cycle.
  - Response: RdData==16'hFFFF.
